fifo_axi_wr_ctrl: RTL and testbench
===================================

# fifo_axi_wr_ctrl

Write-drain controller that sequences a synchronous FIFO (registered read data, registered `full`/`empty` flags) into an AXI4 memory-mapped master write port. It accepts a job command (base address and beat count), splits the job into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary, and pops one FIFO word per W beat. It sits between the streaming FIFO and the AXI interconnect in the AXI-MM test datapath.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, FIFO and W data width; power of two, 8..1024
- MAX_BURST, 16, maximum beats per burst; 1..256
- LEN_WIDTH, 16, width of the job beat count
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  job handshake
- cmd_addr  in  ADDR_WIDTH  job byte address, aligned to DATA_WIDTH/8
- cmd_beats  in  LEN_WIDTH  job length in beats
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- done_err  out  1  valid with `done`; 1 if any BRESP != OKAY in the job
- fifo_rd_en  out  1  FIFO pop
- fifo_rd_data  in  DATA_WIDTH  FIFO data, valid the cycle after `fifo_rd_en`
- fifo_empty  in  1  FIFO empty flag
- m_axi_awvalid/awready, awaddr[ADDR_WIDTH], awlen[8], awsize[3], awburst[2]  AW channel
- m_axi_wvalid/wready, wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8], wlast  W channel
- m_axi_bvalid/bready, bresp[2]  B channel

## Operation
- States: IDLE, AW, W, B, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch the address and the remaining count. If `cmd_beats`=0, go to DONE. Otherwise compute the burst length and go to AW.
- Burst length = min(remaining, MAX_BURST, (4096 − addr[11:0]) / (DATA_WIDTH/8)).
- AW: drive `awvalid`=1, `awaddr`=current address, `awlen`=len−1, `awsize`=log2(DATA_WIDTH/8), `awburst`=2'b01. AW signals stay stable until `awready`. On the handshake, go to W.
- W: two-entry staging buffer fed from the FIFO.
  - Assert `fifo_rd_en` only when all of the following hold: `fifo_empty`=0, (occupancy + reads in flight) < 2, and beats fetched for this burst < len.
  - Data is captured into the buffer the cycle after `fifo_rd_en`.
  - `wvalid` = buffer non-empty. `wdata` = buffer head. `wstrb` = all ones. `wlast` = 1 on the burst's final beat.
  - Beats are never fetched across a burst boundary.
  - On the `wlast` handshake, go to B.
- B: `bready`=1. On `bvalid`, OR (`bresp`!=0) into the sticky error bit.
  - Then: address += len×(DATA_WIDTH/8) and remaining −= len.
  - If remaining is 0, go to DONE. Otherwise compute the next burst length and go to AW.
- DONE: `done`=1 and `done_err`=sticky error for one cycle, then go to IDLE and clear the sticky error.
- `busy` = (state != IDLE).
- A new command is never accepted while busy.

## Timing
- Reset values: `cmd_ready`=1, `busy`=0, `done`=0, `done_err`=0, `fifo_rd_en`=0, `awvalid`=0, `wvalid`=0, `wlast`=0, `bready`=0. `awaddr`, `awlen`, `wdata` = 0; `awsize` = the constant; `awburst`=01; `wstrb`=0.
- Latency:
  - `cmd_valid` handshake to `awvalid`: 1 cycle.
  - AW handshake to first `fifo_rd_en`: ≤1 cycle.
  - `fifo_rd_en` to `wvalid`: 1 cycle.
- Sustained W throughput is 1 beat/cycle while the FIFO is non-empty and `wready`=1.
- FIFO empty mid-burst: `wvalid` drops after the buffer drains, with no bubble-fill of fake data. The burst resumes when `fifo_empty`=0.
- `wvalid` is never deasserted while `wready`=0 (AXI rule).
- Reset asserted mid-job: every output returns to its reset value immediately. The buffer, counters and sticky error clear. The outstanding AXI transaction is abandoned; the interconnect shares the reset.
- Address arithmetic is modulo 2^ADDR_WIDTH. Remaining count is LEN_WIDTH bits and never underflows.

## Test plan
- Job addr=0x1000, beats=16, FIFO preloaded with 16 words, `wready`=1 → one AW with `awlen`=15; 16 consecutive W beats; `wlast` on beat 16; `done`=1 with `done_err`=0; FIFO empty.
- Job addr=0x0FF8, beats=6, DATA_WIDTH=32 → two bursts: `awaddr`=0x0FF8/`awlen`=1, then `awaddr`=0x1000/`awlen`=3.
- Job beats=40, MAX_BURST=16 → bursts with `awlen` 15, 15, 7 at 0x0, 0x40, 0x80; 40 FIFO pops total.
- FIFO starved mid-burst (4 words, then 5 idle cycles, then 12 words) with random `wready` → `wvalid` gaps; data order is preserved; exactly 16 beats; no pops after the last beat.
- Second burst of the job answered with `bresp`=2'b10 → `done_err`=1 on `done`; the next job reports `done_err`=0.
- `rst_n` pulsed low during the W phase of an 8-beat job → all outputs at reset values; a following job of beats=2 completes normally.
- Job beats=0 → `done` pulse 1 cycle after the command handshake; no `awvalid` and no `fifo_rd_en`.

Source files
------------

// File: rtl/fifo_axi_wr_ctrl.sv
// fifo_axi_wr_ctrl
// Drains a synchronous FIFO (registered read data and flags) into an AXI4
// write master. A job (byte address + beat count) is split into INCR bursts
// of at most MAX_BURST beats that never cross a 4 KB boundary.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_addr,
//   cmd_beats                        job command handshake
//   busy, done, done_err             job status (done_err valid with done)
//   fifo_rd_en, fifo_rd_data,
//   fifo_empty                       FIFO pop side, data valid cycle after pop
//   m_axi_aw*, m_axi_w*, m_axi_b*    AXI4 write address / data / response
module fifo_axi_wr_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    done_err,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_empty,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [8:0]            fetch_q, fetch_d;
    logic [8:0]            sent_q, sent_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    logic [8:0] len;
    logic       pop;
    logic [1:0] wr_idx;

    // Next burst length: min(remaining, MAX_BURST, beats left in the 4 KB page).
    function automatic logic [8:0] burst_len(input logic [ADDR_WIDTH-1:0] a,
                                             input logic [LEN_WIDTH-1:0]  r);
        int unsigned n;
        int unsigned to_4k;
        to_4k = (32'd4096 - 32'(a[11:0])) >> SIZE;
        n     = 32'(MAX_BURST);
        if (32'(r) < n) n = 32'(r);
        if (to_4k < n)  n = to_4k;
        return n[8:0];
    endfunction

    assign len = {1'b0, awlen_q} + 9'd1;

    // The word in flight from the FIFO counts as the buffer tail and is
    // forwarded straight to W when the buffer is otherwise empty; this keeps
    // rd_en-to-wvalid at one cycle and sustains one beat per cycle.
    assign m_axi_wvalid  = (occ_q != 2'd0) || inflight_q;
    assign m_axi_wdata   = (occ_q != 2'd0) ? buf_q[0] :
                           (inflight_q ? fifo_rd_data : '0);
    assign m_axi_wstrb   = (state_q == S_W) ? '1 : '0;
    assign m_axi_wlast   = m_axi_wvalid && (sent_q == len - 9'd1);
    assign pop           = m_axi_wvalid && m_axi_wready;

    assign fifo_rd_en    = (state_q == S_W) && !fifo_empty &&
                           (({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd2) &&
                           (fetch_q < len);

    assign m_axi_awvalid = (state_q == S_AW);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_bready  = (state_q == S_B);

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign done_err      = (state_q == S_DONE) && err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        awlen_d    = awlen_q;
        err_d      = err_q;
        fetch_d    = fetch_q + {8'd0, fifo_rd_en};
        sent_d     = sent_q + {8'd0, pop};
        inflight_d = fifo_rd_en;
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        wr_idx     = occ_q;

        // Staging buffer: pop from head, append the word arriving from the FIFO
        // unless it was consumed directly by this cycle's pop.
        if (pop && occ_q != 2'd0) begin
            buf_d[0] = buf_q[1];
            wr_idx   = occ_q - 2'd1;
        end
        if (inflight_q && !(pop && occ_q == 2'd0)) begin
            buf_d[wr_idx[0]] = fifo_rd_data;
            wr_idx           = wr_idx + 2'd1;
        end
        occ_d = wr_idx;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_beats;
                    if (cmd_beats == '0) begin
                        state_d = S_DONE;
                    end else begin
                        awlen_d = 8'(burst_len(cmd_addr, cmd_beats) - 9'd1);
                        state_d = S_AW;
                    end
                end
            end
            S_AW: begin
                if (m_axi_awready) begin
                    fetch_d = '0;
                    sent_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (pop && m_axi_wlast) state_d = S_B;
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    err_d  = err_q | (m_axi_bresp != 2'b00);
                    addr_d = addr_q + (ADDR_WIDTH'(len) << SIZE);
                    rem_d  = rem_q - LEN_WIDTH'(len);
                    if (rem_d == '0) begin
                        state_d = S_DONE;
                    end else begin
                        awlen_d = 8'(burst_len(addr_d, rem_d) - 9'd1);
                        state_d = S_AW;
                    end
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            awlen_q    <= '0;
            fetch_q    <= '0;
            sent_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            awlen_q    <= awlen_d;
            fetch_q    <= fetch_d;
            sent_q     <= sent_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end
endmodule

// File: tb/tb_fifo_axi_wr_ctrl.sv
// Bench for fifo_axi_wr_ctrl: FIFO model, random AXI slave and a job-level
// reference (burst plan, data scoreboard, error tracking) checked every cycle.
module tb_fifo_axi_wr_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        busy, done, done_err;
    logic        fifo_rd_en, fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [3:0]  wstrb;

    fifo_axi_wr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .busy(busy), .done(done),
        .done_err(done_err), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } burst_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    logic [31:0] q_fifo[$];
    logic [31:0] exp_data[$];
    burst_t      exp_bursts[$];
    burst_t      aw_log[$];
    int          open_lens[$];
    int          b_pend[$];
    int w_idx, wburst_num, pops, job_beats, hs_cyc, w_hs_cnt, first_w_cyc, last_w_cyc;
    int jobs_done = 0;
    bit exp_err, first_aw_seen, b_drop, last_done_err;
    int feed_left = 0, feed_cnt, feed_pause_after, feed_pause_len, pause_ctr;
    bit feed_rand = 0, wr_rand = 0, aw_rand = 0;
    int err_burst = -1;
    logic prev_awv, prev_awr, prev_wv, prev_wr;
    logic [31:0] prev_awaddr, prev_wdata;
    bit pend_pop, pend_push;
    logic [31:0] pend_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page.
    function automatic int plan_len(input logic [31:0] a, input int r);
        int room, m;
        room = (4096 - int'(a[11:0])) / 4;
        m = r;
        if (m > 16) m = 16;
        if (room < m) m = room;
        return m;
    endfunction

    // FIFO model: registered data and empty flag update just after the edge.
    initial begin
        fifo_rd_data = '0;
        fifo_empty   = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                if (pend_pop && q_fifo.size() > 0) fifo_rd_data = q_fifo.pop_front();
                if (pend_push) q_fifo.push_back(pend_data);
            end
            fifo_empty = (q_fifo.size() == 0);
        end
    end

    // Monitor, AXI slave, FIFO feeder and reference model.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        pend_pop = 0; pend_push = 0; pend_data = '0; b_drop = 0;
        prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            pend_pop = 0; pend_push = 0;
            if (!rst_n) begin
                check("reset_ctrl", {cmd_ready, busy, done, done_err, fifo_rd_en, awvalid, wvalid, wlast, bready},
                      9'b100000000);
                check("reset_aw", {awaddr, awlen, awsize, awburst}, {32'h0, 8'h0, 3'd2, 2'b01});
                check("reset_w", {wdata, wstrb}, {32'h0, 4'h0});
                q_fifo.delete(); exp_data.delete(); exp_bursts.delete();
                open_lens.delete(); b_pend.delete();
                w_idx = 0; exp_err = 0; feed_left = 0; pause_ctr = 0; b_drop = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
                continue;
            end
            // AXI stability while the slave stalls
            if (prev_awv && !prev_awr) check("aw_stable", {awvalid, awaddr}, {1'b1, prev_awaddr});
            if (prev_wv && !prev_wr) check("w_stable", {wvalid, wdata}, {1'b1, prev_wdata});
            check("ready_vs_busy", cmd_ready, !busy);
            if (fifo_rd_en) begin
                check("pop_nonempty", fifo_empty, 0);
                check("pop_while_busy", busy, 1);
                pops++; pend_pop = 1;
            end
            if (cmd_valid && cmd_ready) begin
                logic [31:0] a; int r, l;
                a = cmd_addr; r = int'(cmd_beats);
                exp_bursts.delete();
                while (r > 0) begin
                    l = plan_len(a, r);
                    exp_bursts.push_back({a, 32'(l)});
                    a = a + 32'(l * 4); r = r - l;
                end
                job_beats = int'(cmd_beats); hs_cyc = cyc; first_aw_seen = 0;
                pops = 0; exp_err = 0; wburst_num = 0; w_hs_cnt = 0; w_idx = 0;
                aw_log.delete();
            end
            // AW channel
            awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (awvalid) begin
                check("aw_expected", exp_bursts.size() > 0, 1);
                if (!first_aw_seen) begin
                    check("aw_latency", cyc, hs_cyc + 1);
                    first_aw_seen = 1;
                end
                if (awready && exp_bursts.size() > 0) begin
                    burst_t b;
                    b = exp_bursts.pop_front();
                    check("awaddr", awaddr, b.addr);
                    check("awlen", awlen, b.len - 1);
                    check("awsize_burst", {awsize, awburst}, {3'd2, 2'b01});
                    open_lens.push_back(int'(b.len));
                    aw_log.push_back({awaddr, 24'h0, awlen});
                end
            end
            // W channel
            wready = wr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (wvalid) begin
                check("wvalid_in_burst", open_lens.size() > 0, 1);
                check("wstrb", wstrb, 4'hF);
                if (wready && open_lens.size() > 0) begin
                    check("wdata_avail", exp_data.size() > 0, 1);
                    if (exp_data.size() > 0) check("wdata", wdata, exp_data.pop_front());
                    check("wlast", wlast, w_idx == open_lens[0] - 1);
                    if (w_hs_cnt == 0) first_w_cyc = cyc;
                    last_w_cyc = cyc; w_hs_cnt++; w_idx++;
                    if (w_idx == open_lens[0]) begin
                        void'(open_lens.pop_front());
                        w_idx = 0;
                        b_pend.push_back(wburst_num++);
                    end
                end
            end
            // B channel
            if (b_drop) begin bvalid = 0; bresp = 0; b_drop = 0; end
            if (!bvalid && b_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                bvalid = 1;
                bresp  = (b_pend[0] == err_burst) ? 2'b10 : 2'b00;
            end
            if (bvalid && bready) begin
                if (bresp != 2'b00) exp_err = 1;
                void'(b_pend.pop_front());
                b_drop = 1;
            end
            // Job end
            if (done) begin
                check("done_err", done_err, exp_err);
                check("bursts_all_issued", exp_bursts.size(), 0);
                check("pops_per_job", pops, job_beats);
                check("data_all_sent", exp_data.size(), 0);
                if (job_beats == 0) check("zero_done_latency", cyc, hs_cyc + 1);
                last_done_err = done_err;
                jobs_done++;
            end else begin
                check("done_err_idle", done_err, 0);
            end
            // FIFO feeder
            if (feed_left > 0) begin
                if (pause_ctr > 0) pause_ctr--;
                else if (!(feed_rand && $urandom_range(0, 2) == 0)) begin
                    pend_push = 1; pend_data = $urandom;
                    exp_data.push_back(pend_data);
                    feed_left--; feed_cnt++;
                    if (feed_cnt == feed_pause_after) pause_ctr = feed_pause_len;
                end
            end
            prev_awv = awvalid; prev_awr = awready; prev_awaddr = awaddr;
            prev_wv = wvalid; prev_wr = wready; prev_wdata = wdata;
        end
    end

    task automatic feed(input int n, input int p_after, input int p_len, input bit rnd);
        @(negedge clk);
        feed_cnt = 0; feed_pause_after = p_after; feed_pause_len = p_len;
        feed_rand = rnd; pause_ctr = 0; feed_left = n;
    endtask

    task automatic preload(input int n);
        int t = 0;
        feed(n, -1, 0, 0);
        while (feed_left > 0 && t < 500) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic start_job(input logic [31:0] a, input int b);
        @(negedge clk);
        cmd_valid = 1; cmd_addr = a; cmd_beats = 16'(b);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int start, t;
        start = jobs_done; t = 0;
        while (jobs_done == start && t < 3000) begin @(negedge clk); t++; end
        check("job_completes", jobs_done != start, 1);
    endtask

    initial begin
        rst_n = 1; cmd_valid = 0; cmd_addr = '0; cmd_beats = '0;
        #3 rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        // pin the burst planner to hand-computed splits
        check("plan_ff8", plan_len(32'h0FF8, 6), 2);
        check("plan_1000", plan_len(32'h1000, 4), 4);
        check("plan_max", plan_len(32'h0, 40), 16);
        check("plan_page_end", plan_len(32'h0FFC, 9), 1);

        // single full burst, back-to-back beats
        preload(16);
        start_job(32'h1000, 16); wait_done();
        check("t1_aw_count", aw_log.size(), 1);
        if (aw_log.size() == 1) check("t1_awlen", aw_log[0].len, 15);
        check("t1_beats", w_hs_cnt, 16);
        check("t1_consecutive", last_w_cyc - first_w_cyc, 15);
        check("t1_fifo_empty", fifo_empty, 1);
        check("t1_done_err", last_done_err, 0);

        // 4 KB crossing
        preload(6);
        start_job(32'h0FF8, 6); wait_done();
        check("t2_aw_count", aw_log.size(), 2);
        if (aw_log.size() == 2) begin
            check("t2_aw0", {aw_log[0].addr, aw_log[0].len}, {32'h0FF8, 32'd1});
            check("t2_aw1", {aw_log[1].addr, aw_log[1].len}, {32'h1000, 32'd3});
        end

        // MAX_BURST split
        preload(40);
        start_job(32'h0, 40); wait_done();
        check("t3_aw_count", aw_log.size(), 3);
        if (aw_log.size() == 3) begin
            check("t3_aw0", {aw_log[0].addr, aw_log[0].len}, {32'h00, 32'd15});
            check("t3_aw1", {aw_log[1].addr, aw_log[1].len}, {32'h40, 32'd15});
            check("t3_aw2", {aw_log[2].addr, aw_log[2].len}, {32'h80, 32'd7});
        end
        check("t3_pops", pops, 40);

        // starved FIFO with random wready
        wr_rand = 1;
        feed(16, 4, 5, 0);
        start_job(32'h2000, 16); wait_done();
        check("t4_beats", w_hs_cnt, 16);
        repeat (5) @(negedge clk);
        check("t4_no_extra_pops", pops, 16);

        // error on second burst, then a clean job
        err_burst = 1;
        preload(40);
        start_job(32'h0, 40); wait_done();
        check("t5_err", last_done_err, 1);
        err_burst = -1;
        preload(4);
        start_job(32'h100, 4); wait_done();
        check("t5_err_cleared", last_done_err, 0);

        // reset during W phase
        begin
            int t = 0;
            feed(8, -1, 0, 0);
            start_job(32'h3000, 8);
            while (w_hs_cnt < 2 && t < 500) begin @(negedge clk); t++; end
            check("t6_reached_w", w_hs_cnt >= 2, 1);
            rst_n = 0;
            repeat (2) @(negedge clk);
            rst_n = 1;
            preload(2);
            start_job(32'h4000, 2); wait_done();
            check("t6_beats", w_hs_cnt, 2);
            check("t6_done_err", last_done_err, 0);
        end

        // zero-length job
        start_job(32'h500, 0); wait_done();
        check("t7_no_aw", aw_log.size(), 0);
        check("t7_no_pops", pops, 0);

        // random jobs
        aw_rand = 1;
        for (int j = 0; j < 10; j++) begin
            logic [31:0] a;
            int b;
            a = {$urandom_range(0, 255), 12'h0};
            a[11:0] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(1000, 1023) * 4)
                                                  : 12'($urandom_range(0, 1023) * 4);
            b = $urandom_range(0, 48);
            err_burst = $urandom_range(0, 3) - 1;
            feed(b, $urandom_range(1, 8), $urandom_range(0, 6), 1);
            start_job(a, b); wait_done();
            check("rand_beats", w_hs_cnt, b);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
